// File: rtl/vm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vm_pkg
// Description : Shared types, lane constants and sign-byte helper for the
//               vedic multiplier result path.
// Revision    : 1.0 - initial release
// ============================================================================
package vm_pkg;

    typedef enum logic [1:0] {
        OP_MUL   = 2'b00,
        OP_MULH  = 2'b01,
        OP_MULHU = 2'b10,
        OP_MULSU = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        PREC_8    = 2'b00,
        PREC_16   = 2'b01,
        PREC_32   = 2'b10,
        PREC_RSVD = 2'b11
    } prec_e;

    localparam int C_LANES_8  = 4;
    localparam int C_LANES_16 = 2;
    localparam int C_LANES_32 = 1;

    // Byte holding the operand sign bit for a lane: its most-significant byte.
    function automatic logic [1:0] lane_sign_byte(input prec_e prec, input logic [1:0] lane);
        case (prec)
            PREC_16: lane_sign_byte = (lane == 2'd0) ? 2'd1 : 2'd3;
            PREC_32: lane_sign_byte = 2'd3;
            default: lane_sign_byte = lane;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/tc_product_stream_with_precision.sv
`default_nettype none
// ============================================================================
// Module      : tc_product_stream_with_precision
// Description : Combinational lane-segmented two's-complement negator for the
//               64-bit magnitude product; carries never cross a lane.
// Revision    : 1.0 - initial release
// ============================================================================
module tc_product_stream_with_precision
    import vm_pkg::*;
(
    input  logic [63:0] product,
    input  logic [3:0]  neg,
    input  logic [1:0]  precision,
    output logic [63:0] result
);

    logic [63:0] w_seg16;
    logic [63:0] w_seg32;
    logic [63:0] w_seg64;

    // Each segmentation is negated independently, so no carry chain spans lanes.
    for (genvar i = 0; i < C_LANES_8; i++) begin : g_seg16
        assign w_seg16[16*i +: 16] = neg[i] ? (~product[16*i +: 16] + 16'd1)
                                            : product[16*i +: 16];
    end

    for (genvar j = 0; j < C_LANES_16; j++) begin : g_seg32
        assign w_seg32[32*j +: 32] = neg[j] ? (~product[32*j +: 32] + 32'd1)
                                            : product[32*j +: 32];
    end

    assign w_seg64 = neg[0] ? (~product + 64'd1) : product;

    always_comb begin
        case (prec_e'(precision))
            PREC_16: result = w_seg32;
            PREC_32: result = w_seg64;
            default: result = w_seg16;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/vm_result_tc_stage.sv
`default_nettype none
// ============================================================================
// Module      : vm_result_tc_stage
// Description : Re-signs lane products, selects low/high halves and delivers
//               the packed 32-bit result through a 2-stage valid/ready pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module vm_result_tc_stage
    import vm_pkg::*;
#(
    parameter bit PIPE_BYPASS_S1 = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] product,
    input  logic [3:0]  sign_a,
    input  logic [3:0]  sign_b,
    input  logic [1:0]  opcode,
    input  logic [1:0]  precision,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);

    logic [3:0]  w_neg;
    logic [63:0] w_tc_data;
    logic        w_s1_valid;
    logic [63:0] w_s1_data;
    opcode_e     w_s1_op;
    prec_e       w_s1_prec;
    logic        w_s1_en;
    logic        w_s2_en;
    logic        w_hi;
    logic [31:0] w_packed;
    logic        r_out_valid;
    logic [31:0] r_result;

    always_comb begin
        w_neg = '0;
        for (int i = 0; i < C_LANES_8; i++) begin
            w_neg[i] = sign_a[lane_sign_byte(prec_e'(precision), 2'(i))]
                     ^ sign_b[lane_sign_byte(prec_e'(precision), 2'(i))];
        end
    end

    tc_product_stream_with_precision u_tc (
        .product   (product),
        .neg       (w_neg),
        .precision (precision),
        .result    (w_tc_data)
    );

    assign w_s2_en = !r_out_valid || out_ready;

    if (PIPE_BYPASS_S1) begin : g_s1_bypass
        // in_ready comes from the output stage only, keeping it independent of in_valid.
        assign w_s1_valid = in_valid;
        assign w_s1_data  = w_tc_data;
        assign w_s1_op    = opcode_e'(opcode);
        assign w_s1_prec  = prec_e'(precision);
        assign w_s1_en    = w_s2_en;
    end else begin : g_s1_reg
        logic        r_s1_valid;
        logic [63:0] r_s1_data;
        opcode_e     r_s1_op;
        prec_e       r_s1_prec;

        assign w_s1_en = !r_s1_valid || w_s2_en;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_s1_valid <= 1'b0;
                r_s1_data  <= '0;
                r_s1_op    <= OP_MUL;
                r_s1_prec  <= PREC_8;
            end else if (w_s1_en) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_data <= w_tc_data;
                    r_s1_op   <= opcode_e'(opcode);
                    r_s1_prec <= prec_e'(precision);
                end
            end
        end

        assign w_s1_valid = r_s1_valid;
        assign w_s1_data  = r_s1_data;
        assign w_s1_op    = r_s1_op;
        assign w_s1_prec  = r_s1_prec;
    end

    assign w_hi = (w_s1_op != OP_MUL);

    always_comb begin
        w_packed = '0;
        case (w_s1_prec)
            PREC_16: begin
                for (int j = 0; j < C_LANES_16; j++) begin
                    w_packed[16*j +: 16] = w_hi ? w_s1_data[32*j + 16 +: 16]
                                                : w_s1_data[32*j +: 16];
                end
            end
            PREC_32: w_packed = w_hi ? w_s1_data[63:32] : w_s1_data[31:0];
            default: begin
                for (int i = 0; i < C_LANES_8; i++) begin
                    w_packed[8*i +: 8] = w_hi ? w_s1_data[16*i + 8 +: 8]
                                              : w_s1_data[16*i +: 8];
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_result    <= '0;
        end else if (w_s2_en) begin
            r_out_valid <= w_s1_valid;
            if (w_s1_valid) begin
                r_result <= w_packed;
            end
        end
    end

    assign in_ready  = w_s1_en;
    assign out_valid = r_out_valid;
    assign result    = r_result;

endmodule
`default_nettype wire

// File: tb/tb_vm_result_tc_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_vm_result_tc_stage
// Description : Scoreboard bench for vm_result_tc_stage, normal and bypass.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vm_result_tc_stage;
    import vm_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
    logic [63:0] a_product;
    logic [3:0]  a_sa, a_sb;
    logic [1:0]  a_op, a_prec;
    logic [31:0] a_result;
    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
    logic [63:0] b_product;
    logic [3:0]  b_sa, b_sb;
    logic [1:0]  b_op, b_prec;
    logic [31:0] b_result;

    vm_result_tc_stage #(.PIPE_BYPASS_S1(1'b0)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .product(a_product), .sign_a(a_sa), .sign_b(a_sb), .opcode(a_op),
        .precision(a_prec), .out_valid(a_out_valid), .out_ready(a_out_ready),
        .result(a_result)
    );

    vm_result_tc_stage #(.PIPE_BYPASS_S1(1'b1)) dut_bp (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .product(b_product), .sign_a(b_sa), .sign_b(b_sb), .opcode(b_op),
        .precision(b_prec), .out_valid(b_out_valid), .out_ready(b_out_ready),
        .result(b_result)
    );

    typedef struct {
        logic [31:0] res;
        int          cyc;
        bit          chk;
    } exp_t;

    exp_t        qa[$];
    exp_t        qb[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    bit          stall_prev[2];
    logic [31:0] res_prev[2];
    bit          head_seen[2];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input bit bp, input logic [1:0] op, input logic [1:0] prec,
                        input logic [63:0] p, input logic [3:0] sa, input logic [3:0] sb,
                        input logic [31:0] exp, input bit chk);
        exp_t e;
        int   n;
        if (!bp) begin
            a_in_valid = 1'b1; a_op = op; a_prec = prec; a_product = p; a_sa = sa; a_sb = sb;
        end else begin
            b_in_valid = 1'b1; b_op = op; b_prec = prec; b_product = p; b_sa = sa; b_sb = sb;
        end
        n = 0;
        @(negedge clk);
        while (!(bp ? b_in_ready : a_in_ready) && n < 100) begin
            n++;
            @(negedge clk);
        end
        if (n >= 100) begin
            total++; bad++;
            $display("FAIL %s accept timeout: in_ready stayed 0, required 1", bp ? "B" : "A");
        end else begin
            e = '{exp, cyc, chk};
            if (bp) qb.push_back(e); else qa.push_back(e);
        end
        @(posedge clk); #1;
        if (bp) b_in_valid = 1'b0; else a_in_valid = 1'b0;
    endtask

    task automatic mon(input bit bp);
        logic        v, r;
        logic [31:0] res;
        int          lat;
        exp_t        h;
        v   = bp ? b_out_valid : a_out_valid;
        r   = bp ? b_out_ready : a_out_ready;
        res = bp ? b_result : a_result;
        lat = bp ? 1 : 2;
        if (stall_prev[bp]) begin
            check(bp ? "B hold valid" : "A hold valid", {31'd0, v}, 32'd1);
            check(bp ? "B hold result" : "A hold result", res, res_prev[bp]);
        end
        stall_prev[bp] = v && !r;
        res_prev[bp]   = res;
        if (!v) return;
        if ((bp ? qb.size() : qa.size()) == 0) begin
            total++; bad++;
            $display("FAIL %s unexpected output: got %h with empty scoreboard", bp ? "B" : "A", res);
            return;
        end
        h = bp ? qb[0] : qa[0];
        if (!head_seen[bp]) begin
            head_seen[bp] = 1'b1;
            if (h.chk) check(bp ? "B latency" : "A latency", 32'(cyc - h.cyc), 32'(lat));
        end
        if (r) begin
            check(bp ? "B result" : "A result", res, h.res);
            if (bp) void'(qb.pop_front()); else void'(qa.pop_front());
            head_seen[bp] = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        mon(1'b0);
        mon(1'b1);
    end

    task automatic flush();
        qa.delete();
        qb.delete();
        stall_prev[0] = 1'b0; stall_prev[1] = 1'b0;
        head_seen[0]  = 1'b0; head_seen[1]  = 1'b0;
    endtask

    task automatic wait_empty(input bit bp);
        int n;
        n = 0;
        while ((bp ? qb.size() : qa.size()) != 0 && n < 50) begin
            n++;
            @(posedge clk);
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL %s drain timeout: %0d items left, required 0", bp ? "B" : "A",
                     bp ? qb.size() : qa.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        int c0;
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_out_ready = 1'b1; a_product = '0; a_sa = '0; a_sb = '0; a_op = '0; a_prec = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b1; b_product = '0; b_sa = '0; b_sb = '0; b_op = '0; b_prec = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset out_valid", {31'd0, a_out_valid}, 32'd0);
        check("reset result", a_result, 32'd0);
        check("reset in_ready", {31'd0, a_in_ready}, 32'd1);
        check("reset B out_valid", {31'd0, b_out_valid}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // 32-bit re-sign, low and high half
        send(0, OP_MUL,  PREC_32, 64'h0000_0000_0000_000F, 4'hF, 4'h0, 32'hFFFF_FFF1, 1);
        send(0, OP_MULH, PREC_32, 64'h0000_0000_0000_000F, 4'hF, 4'h0, 32'hFFFF_FFFF, 1);
        // 8-bit lanes, lanes 0 and 2 negated
        send(0, OP_MUL,  PREC_8, 64'h0001_0004_0009_0006, 4'b0001, 4'b0100, 32'h01FC_09FA, 1);
        send(0, OP_MULH, PREC_8, 64'h0001_0004_0009_0006, 4'b0001, 4'b0100, 32'h00FF_00FF, 1);
        // 16-bit: only byte 1 / byte 3 carry the lane sign
        send(0, OP_MULHU, PREC_16, 64'h0001_0000_FFFE_0001, 4'b0000, 4'b0000, 32'h0001_FFFE, 1);
        send(0, OP_MULHU, PREC_16, 64'h0001_0000_FFFE_0001, 4'b0001, 4'b0000, 32'h0001_FFFE, 1);
        send(0, OP_MUL,   PREC_16, 64'h0001_0000_FFFE_0001, 4'b0010, 4'b0000, 32'h0000_FFFF, 1);
        // reserved precision behaves as 8-bit
        send(0, OP_MUL,   PREC_RSVD, 64'h0001_0004_0009_0006, 4'b0000, 4'b0000, 32'h0104_0906, 1);
        wait_empty(0);

        c0 = cyc;
        send(0, OP_MUL, PREC_8, 64'h0011_0022_0033_0044, 4'h0, 4'h0, 32'h1122_3344, 1);
        send(0, OP_MUL, PREC_8, 64'h0055_0066_0077_0088, 4'h0, 4'h0, 32'h5566_7788, 1);
        send(0, OP_MUL, PREC_8, 64'h0099_00AA_00BB_00CC, 4'h0, 4'h0, 32'h99AA_BBCC, 1);
        send(0, OP_MUL, PREC_8, 64'h00DD_00EE_00FF_0010, 4'h0, 4'h0, 32'hDDEE_FF10, 1);
        check("A sustain cycles", 32'(cyc - c0), 32'd4);
        wait_empty(0);

        // Stall: only two items fit, the rest wait
        a_out_ready = 1'b0;
        fork
            begin
                send(0, OP_MUL, PREC_8, 64'h0001_0002_0003_0004, 4'h0, 4'h0, 32'h0102_0304, 0);
                send(0, OP_MUL, PREC_8, 64'h0005_0006_0007_0008, 4'h0, 4'h0, 32'h0506_0708, 0);
                send(0, OP_MUL, PREC_8, 64'h0009_000A_000B_000C, 4'h0, 4'h0, 32'h090A_0B0C, 0);
                send(0, OP_MUL, PREC_8, 64'h000D_000E_000F_0010, 4'h0, 4'h0, 32'h0D0E_0F10, 0);
            end
        join_none
        repeat (6) @(negedge clk);
        check("stall accepted count", 32'(qa.size()), 32'd2);
        check("stall in_ready", {31'd0, a_in_ready}, 32'd0);
        check("stall out_valid", {31'd0, a_out_valid}, 32'd1);
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        wait fork;
        wait_empty(0);

        // Reset with both stages full
        a_out_ready = 1'b0;
        send(0, OP_MUL, PREC_32, 64'h0000_0000_1234_5678, 4'h0, 4'h0, 32'h1234_5678, 0);
        send(0, OP_MUL, PREC_32, 64'h0000_0000_9ABC_DEF0, 4'h0, 4'h0, 32'h9ABC_DEF0, 0);
        #2;
        rst_n = 1'b0;
        flush();
        #1;
        check("async reset out_valid", {31'd0, a_out_valid}, 32'd0);
        check("async reset result", a_result, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        a_out_ready = 1'b1;
        check("post reset in_ready", {31'd0, a_in_ready}, 32'd1);
        send(0, OP_MULH, PREC_8, 64'h0001_0004_0009_0006, 4'b0001, 4'b0100, 32'h00FF_00FF, 1);
        wait_empty(0);

        // Bypassed stage 1
        send(1, OP_MUL,  PREC_32, 64'h0000_0000_0000_000F, 4'hF, 4'h0, 32'hFFFF_FFF1, 1);
        send(1, OP_MULH, PREC_32, 64'h0000_0000_0000_000F, 4'hF, 4'h0, 32'hFFFF_FFFF, 1);
        wait_empty(1);
        c0 = cyc;
        send(1, OP_MUL,  PREC_16, 64'h0000_0003_0000_0005, 4'h0, 4'h2, 32'h0003_FFFB, 1);
        send(1, OP_MULH, PREC_16, 64'h0000_0003_0000_0005, 4'h8, 4'h0, 32'hFFFF_0000, 1);
        send(1, OP_MULSU, PREC_8, 64'h0102_0304_0506_0708, 4'h0, 4'h0, 32'h0103_0507, 1);
        send(1, OP_MUL,  PREC_8,  64'h0102_0304_0506_0708, 4'hF, 4'h0, 32'hFEFC_FAF8, 1);
        check("B sustain cycles", 32'(cyc - c0), 32'd4);
        wait_empty(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/vm_result_tc_stage.md
Name: vm_result_tc_stage

Overview:
- Downstream consumer of the vedic multiplier array. It receives the unsigned magnitude product of two operands that the operand two's-complement stage has already made positive. It also receives that stage's per-byte sign vectors for operand A and operand B.
- It re-applies the sign per lane, honouring precision, then selects the low or high half of each lane product per opcode.
- It packs the 32-bit vector result and delivers it through a 2-stage valid/ready pipeline to the writeback/output interface.

Parameters:
- PIPE_BYPASS_S1, 0, when 1 the stage-1 register becomes combinational and latency drops to 1; the handshake rules are unchanged.

Ports:
- clk  in  1  single clock, rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream has a product.
- in_ready  out  1  stage can accept this cycle.
- product  in  64  lane-packed magnitude product.
  - prec 00/11: four 16-bit lane products, lane i at [16i+15:16i].
  - prec 01: two 32-bit lane products at [32j+31:32j].
  - prec 10: one 64-bit product.
- sign_a  in  4  per-byte negate flags of operand A, bit i = byte i.
- sign_b  in  4  per-byte negate flags of operand B.
- opcode  in  2  00 MUL, 01 MULH, 10 MULHU, 11 MULSU.
- precision  in  2  00 8-bit, 01 16-bit, 10 32-bit, 11 treated as 8-bit.
- out_valid  out  1  result is valid.
- out_ready  in  1  downstream accepts.
- result  out  32  packed signed/unsigned vector result.

Behaviour:
- Reset (async assert, sync deassert use): out_valid=0, result=0, all internal valid bits 0, in_ready=1 after reset.
- A transfer occurs on valid&&ready at the rising edge. Latency is input transfer to out_valid = 2 cycles, or 1 cycle if PIPE_BYPASS_S1=1. Throughput is 1 per cycle when out_ready=1.
- Stage 1 (register S1): latch opcode/precision. Compute lane negate flags neg[i] = sign_a[k]^sign_b[k], where k is the lane's most-significant byte:
  - 8-bit: k=i.
  - 16-bit: k=1 for lane 0, k=3 for lane 1.
  - 32-bit: k=3.
  - Apply a lane-segmented two's complement to product: a lane is inverted and incremented only if its neg flag is set. The carry must not cross a lane boundary.
- Stage 2 (register S2/output): per lane of width N, select the low N bits for MUL and the high N bits for MULH/MULHU/MULSU. Pack as follows:
  - 8-bit: result[8i+7:8i] = lane i half.
  - 16-bit: result[16j+15:16j].
  - 32-bit: the single half.
- Negation of a zero lane yields zero; no special case is needed.
- Upstream is responsible for clearing sign flags for unsigned operands (MULHU both, MULSU operand B). This stage does not re-gate by opcode.
- Handshake:
  - s2_en = !out_valid || out_ready.
  - s1_en = !s1_valid || s2_en.
  - in_ready = s1_en.
  - out_valid and result hold stable while out_valid && !out_ready.
  - Valid must not drop without a transfer.
- Simultaneous transfer in and out in the same cycle with a full pipeline: both stages advance, with no bubble and no loss.
- Reset asserted mid-operation: in-flight data is discarded, and out_valid falls immediately (asynchronously).
- in_ready must not depend combinationally on in_valid.

Decomposition:
- Shared package vm_pkg:
  - opcode_e (OP_MUL, OP_MULH, OP_MULHU, OP_MULSU).
  - prec_e (PREC_8, PREC_16, PREC_32, PREC_RSVD).
  - lane-count constants.
  - function lane_sign_byte(prec, lane).
- Sub-module tc_product_stream_with_precision: a purely combinational 64-bit lane-segmented negator with inputs neg[3:0] and precision.

Test Plan:
- 32-bit MUL, product=64'h0000_0000_0000_000F, sign_a=4'hF, sign_b=0 → result 32'hFFFF_FFF1 two cycles after the transfer. MULH with the same inputs → 32'hFFFF_FFFF.
- 8-bit MUL, product lanes {0x0001,0x0004,0x0009,0x0006}, sign_a=4'b0001, sign_b=4'b0100 → result 32'h01_FC_09_FA (lane0 negated, lane2 negated, lanes 1/3 positive). MULH with the same inputs → 32'h00_FF_00_FF.
- 16-bit MULHU, product={32'h0001_0000, 32'hFFFE_0001}, sign_a=sign_b=0 → result 32'h0001_FFFE. Also check that an operand sign set on byte 0 only does not negate lane 0 (only byte 1 counts).
- Back-to-back: 4 transfers with out_ready held low from cycle 1:
  - in_ready drops after 2 accepted items.
  - out_valid/result stay stable.
  - releasing out_ready drains the items in order with no loss or duplication.
- Reset asserted while both stages are valid → out_valid=0 and result=0 asynchronously. After deassert, in_ready=1 and the first new item emerges with 2-cycle latency.
- PIPE_BYPASS_S1=1: repeat test 1 → result after 1 cycle. Simultaneous in/out transfer with a full pipeline each cycle sustains 1 result/cycle.
